// File: rtl/rv32_decode_stage.sv
// RV32 instruction decode stage: regfile read with writeback bypass, immediate
// and control generation, load-use hazard bubble, and the ID/EX pipeline register.
module rv32_decode_stage #(
  parameter bit NOP_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_valid_i,
  output logic        if_ready_o,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic [4:0]  rf_rs1_addr_o,
  output logic [4:0]  rf_rs2_addr_o,
  input  logic [31:0] rf_rs1_data_i,
  input  logic [31:0] rf_rs2_data_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [31:0] ex_rs1_data_o,
  output logic [31:0] ex_rs2_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_rd_we_o,
  output logic [6:0]  ex_opcode_o,
  output logic [2:0]  ex_funct3_o,
  output logic        ex_funct7b5_o,
  output logic        ex_is_load_o,
  output logic        ex_illegal_o
);

  // Major opcodes keyed on inst[6:2]; inst[1:0] is checked separately.
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [31:0] instr;
  logic [4:0]  op5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        known;
  logic        writes_rd;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        is_load;
  logic        illegal;
  logic        rd_we;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        hazard;
  logic        accept;

  assign instr = if_instr_i;
  assign op5   = instr[6:2];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rd    = instr[11:7];

  assign rf_rs1_addr_o = rs1;
  assign rf_rs2_addr_o = rs2;

  // Immediate format and register usage per opcode class.
  always_comb begin
    imm       = '0;
    known     = 1'b1;
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    is_load   = 1'b0;
    case (op5)
      OP_LOAD: begin
        imm       = {{20{instr[31]}}, instr[31:20]};
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        is_load   = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        imm       = {{20{instr[31]}}, instr[31:20]};
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OP_STORE: begin
        imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm       = {instr[31:12], 12'h000};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        imm       = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_OP: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_MISC, OP_SYSTEM: ;
      default: known = 1'b0;
    endcase
  end

  assign illegal = !known || (NOP_CHECK && (instr[1:0] != 2'b11));
  assign rd_we   = writes_rd && (rd != 5'd0) && !illegal;

  // x0 reads as zero; a same-cycle writeback overrides the stale regfile value.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 :
                   (wb_we_i && (wb_rd_i == rs1)) ? wb_data_i : rf_rs1_data_i;
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 :
                   (wb_we_i && (wb_rd_i == rs2)) ? wb_data_i : rf_rs2_data_i;

  assign hazard = ex_valid_o && ex_is_load_o && (ex_rd_o != 5'd0) &&
                  ((uses_rs1 && (rs1 == ex_rd_o)) || (uses_rs2 && (rs2 == ex_rd_o)));

  assign if_ready_o = flush_i || ((!ex_valid_o || ex_ready_i) && !hazard);
  assign accept     = if_valid_i && if_ready_o;

  // ID/EX register: flush beats load beats drain; otherwise hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rd_o       <= '0;
      ex_rd_we_o    <= 1'b0;
      ex_opcode_o   <= '0;
      ex_funct3_o   <= '0;
      ex_funct7b5_o <= 1'b0;
      ex_is_load_o  <= 1'b0;
      ex_illegal_o  <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (accept) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= if_pc_i;
      ex_rs1_data_o <= rs1_val;
      ex_rs2_data_o <= rs2_val;
      ex_imm_o      <= imm;
      ex_rd_o       <= rd;
      ex_rd_we_o    <= rd_we;
      ex_opcode_o   <= instr[6:0];
      ex_funct3_o   <= instr[14:12];
      ex_funct7b5_o <= instr[30];
      ex_is_load_o  <= is_load;
      ex_illegal_o  <= illegal;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- ID stage of the RV32 core. Accepts instructions and PCs from fetch over a valid/ready handshake.
- Drives the register-file read addresses and takes the read data back, with a same-cycle writeback bypass.
- Generates the immediate and control fields, detects load-use hazards, and registers the result into the ID/EX pipeline register for execute.

Parameters:
- NOP_CHECK, 1, when 1 an instruction with inst[1:0]!=2'b11 is flagged illegal; when 0 those bits are ignored.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- if_valid_i  in  1  fetch has an instruction
- if_ready_o  out  1  decode accepts this cycle
- if_instr_i  in  32  instruction word
- if_pc_i  in  32  instruction PC
- rf_rs1_addr_o  out  5  regfile read address A
- rf_rs2_addr_o  out  5  regfile read address B
- rf_rs1_data_i  in  32  regfile read data A (combinational)
- rf_rs2_data_i  in  32  regfile read data B (combinational)
- wb_we_i  in  1  writeback write enable, same cycle as regfile write
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  32  writeback data
- flush_i  in  1  redirect from execute; kill ID/EX contents and the incoming instruction
- ex_ready_i  in  1  execute accepts
- ex_valid_o  out  1  ID/EX register holds a valid instruction
- ex_pc_o  out  32  PC
- ex_rs1_data_o  out  32  operand A
- ex_rs2_data_o  out  32  operand B
- ex_imm_o  out  32  sign-extended immediate
- ex_rd_o  out  5  destination register
- ex_rd_we_o  out  1  destination write enable
- ex_opcode_o  out  7  inst[6:0]
- ex_funct3_o  out  3  inst[14:12]
- ex_funct7b5_o  out  1  inst[30]
- ex_is_load_o  out  1  opcode LOAD
- ex_illegal_o  out  1  unsupported encoding

Behaviour:
- **Reset.** rst_i high forces every ex_* output to 0 immediately (asynchronous), including ex_valid_o. Releasing reset leaves the register empty.
- **Regfile addresses.** rf_rs1_addr_o = if_instr_i[19:15] and rf_rs2_addr_o = if_instr_i[24:20], driven combinationally regardless of if_valid_i.
- **Operand select.** For each operand:
  - address 0 → 0;
  - else if wb_we_i && wb_rd_i==address → wb_data_i;
  - else the regfile data.
- **Immediate by opcode** (all sign-extended from inst[31]):
  - I for LOAD 0000011, OP-IMM 0010011, JALR 1100111;
  - S for 0100011;
  - B for 1100011, bit 0 = 0;
  - U for LUI 0110111 and AUIPC 0010111, low 12 bits = 0;
  - J for 1101111, bit 0 = 0;
  - all other opcodes → 0.
- **Legal opcodes.** The above plus OP 0110011, FENCE 0001111 and SYSTEM 1110011. Any other opcode is illegal, and so is inst[1:0]!=2'b11 when NOP_CHECK=1. An illegal instruction sets ex_illegal_o=1 and ex_rd_we_o=0.
- **Destination write enable.** ex_rd_we_o = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0.
- **Register usage.**
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- **Hazard.** hazard = ex_valid_o && ex_is_load_o && ex_rd_o!=0 && ((uses_rs1 && rs1==ex_rd_o) || (uses_rs2 && rs2==ex_rd_o)). It is evaluated only against the ID/EX register, so exactly one bubble is inserted.
- **if_ready_o.** Equals flush_i || ((!ex_valid_o || ex_ready_i) && !hazard).
- **Register update on each clk_i edge** (priority order):
  1. flush_i: ex_valid_o ← 0; the incoming instruction is accepted and discarded.
  2. if_valid_i && if_ready_o: load all ex_* fields from the current decode, and set ex_valid_o ← 1.
  3. ex_ready_i (including during a hazard): ex_valid_o ← 0, i.e. a bubble.
  4. Otherwise hold; all ex_* outputs stay bit-stable while ex_valid_o && !ex_ready_i.
- **Data-field clearing.** Data fields are not cleared on a bubble; consumers qualify them with ex_valid_o.
- **Latency.** One cycle from acceptance to ex_valid_o, giving a throughput of 1 instruction/cycle with no hazard and no backpressure.
- **Reset during operation.** Reset asserted mid-stall clears ex_valid_o. After release, the first accepted instruction decodes normally and no stale hazard remains.

Test Plan:
1. Apply reset while ex_valid_o=1 and backpressure is on → all ex_* outputs read 0 in the same cycle; if_ready_o=1 after release.
2. Present ADDI x5,x1,-1 (0xFFF08293) with rf x1=0x10, then BEQ x1,x2,-4 (0xFE208EE3) →
   - ADDI cycle+1: ex_imm_o=0xFFFFFFFF, ex_rs1_data_o=0x10, ex_rd_o=5, ex_rd_we_o=1.
   - BEQ cycle+1: ex_imm_o=0xFFFFFFFC, ex_rd_we_o=0.
3. Present ADDI x5,x1,-1 with rf x1=0x10 while wb_we_i=1, wb_rd_i=1, wb_data_i=0xAB → ex_rs1_data_o=0xAB. Repeat with wb_rd_i=0, wb_data_i=0xFF and the instruction reading x0 → operand 0.
4. Present LW x6,0(x2) (0x00012303) followed by ADD x7,x6,x3 (0x003303B3), with ex_ready_i=1 →
   - if_ready_o=0 for exactly one cycle;
   - ex_valid_o goes 1 (LW), 0 (bubble), 1 (ADD).
5. Hold ex_ready_i=0 for 3 cycles with ex_valid_o=1 → if_ready_o=0 and all ex_* outputs unchanged. On release, the next instruction is accepted in the same cycle.
6. Assert flush_i with ex_valid_o=1 and if_valid_i=1 → ex_valid_o=0 next cycle and the fetched instruction is dropped. Then present 0x0000007F (bad opcode) → ex_illegal_o=1 and ex_rd_we_o=0.
